// File: rtl/pes_bcdbin_arb_if.sv
// Client-side bundle for the BCD->binary arbiter: request levels, per-client
// digits, one-hot grant, one-cycle response pulse with result and error flag.
interface pes_bcdbin_arb_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] req_dig1;
  logic [4*N_REQ-1:0] req_dig0;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   resp_valid;
  logic [6:0]         resp_bin;
  logic               resp_err;

  modport master (
    output req, req_dig1, req_dig0,
    input  gnt, resp_valid, resp_bin, resp_err
  );

  modport slave (
    input  req, req_dig1, req_dig0,
    output gnt, resp_valid, resp_bin, resp_err
  );
endinterface

// File: rtl/pes_bcdbin_arb.sv
// Round-robin sequencer sharing one 2-digit BCD->binary converter.
// Ports: clk, rst_n (sync, active-low), bus (clients, slave side), busy,
//   cv_start/cv_dig1/cv_dig0 to the converter, cv_ready/cv_done_tick/cv_bin back.
module pes_bcdbin_arb #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pes_bcdbin_arb_if.slave  bus,
  output logic             busy,
  output logic             cv_start,
  output logic [3:0]       cv_dig1,
  output logic [3:0]       cv_dig0,
  input  logic             cv_ready,
  input  logic             cv_done_tick,
  input  logic [6:0]       cv_bin
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  win_idx;
  logic           win_found;
  logic [3:0]     win_d1;
  logic [3:0]     win_d0;
  logic           win_ok;
  logic [TW-1:0]  timer;
  logic           timed_out;
  logic [6:0]     res;
  logic           err;
  logic [N_REQ-1:0] sel;

  // Rotating scan starting at ptr; first set request wins.
  always_comb begin
    int j;
    j = 0;
    win_found = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  assign win_d1 = bus.req_dig1[int'(win_idx)*4 +: 4];
  assign win_d0 = bus.req_dig0[int'(win_idx)*4 +: 4];
  assign win_ok = (win_d1 <= 4'd9) && (win_d0 <= 4'd9);
  assign timed_out = (timer == TW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (win_found)
               state_nx = win_ok ? ISSUE : RESP;
      ISSUE: if (cv_ready) state_nx = WAIT;
      WAIT:  if (cv_done_tick || timed_out)
               state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel = '0;
    sel[idx] = 1'b1;
    busy = (state != IDLE);
    cv_start = (state == ISSUE) && cv_ready;
    bus.gnt = busy ? sel : '0;
    bus.resp_valid = (state == RESP) ? sel : '0;
    bus.resp_bin = (state == RESP) ? res : 7'd0;
    bus.resp_err = (state == RESP) && err;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr     <= '0;
      idx     <= '0;
      timer   <= '0;
      res     <= '0;
      err     <= 1'b0;
      cv_dig1 <= '0;
      cv_dig0 <= '0;
    end else begin
      unique case (state)
        IDLE: if (win_found) begin
          idx     <= win_idx;
          cv_dig1 <= win_d1;
          cv_dig0 <= win_d0;
          res     <= '0;
          err     <= !win_ok;
        end
        ISSUE: if (cv_ready) timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (cv_done_tick) begin
            res <= cv_bin;
            err <= 1'b0;
          end else if (timed_out) begin
            res <= '0;
            err <= 1'b1;
          end
        end
        RESP: ptr <= (idx == IW'(N_REQ-1)) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pes_bcdbin_arb.sv
// Randomized bench for pes_bcdbin_arb with a transaction-level reference
// model and a fixed-latency converter stand-in.
module tb_pes_bcdbin_arb;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pes_bcdbin_arb_if #(.N_REQ(N)) bus();

  logic       busy, cv_start, cv_ready, cv_done_tick;
  logic [3:0] cv_dig1, cv_dig0;
  logic [6:0] cv_bin;

  pes_bcdbin_arb #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .cv_start(cv_start), .cv_dig1(cv_dig1), .cv_dig0(cv_dig0),
    .cv_ready(cv_ready), .cv_done_tick(cv_done_tick), .cv_bin(cv_bin)
  );

  // Converter stand-in: done pulse 8 cycles after start.
  int cnt = 0;
  int cval = 0;
  bit suppress = 1'b0;
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 0;
      cval <= 0;
    end else if (cv_start && cnt == 0) begin
      cnt <= 8;
      cval <= 10*int'(cv_dig1) + int'(cv_dig0);
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end
  assign cv_ready = (cnt == 0);
  assign cv_done_tick = (cnt == 1) && !suppress;
  assign cv_bin = 7'(cval);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] rq;
  int d1[N], d0[N];
  int mptr;
  int checks = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p+k)%N]) return (p+k)%N;
    return 0;
  endfunction

  task automatic drive();
    bus.req = rq;
    for (int i = 0; i < N; i++) begin
      bus.req_dig1[4*i +: 4] = 4'(d1[i]);
      bus.req_dig0[4*i +: 4] = 4'(d0[i]);
    end
  endtask

  task automatic txn(input string tag, input bit drop_mid,
                     output int w, output int g0);
    int n, starts, eb, ee, el;
    bit ok;
    w = winner(rq, mptr);
    ok = (d1[w] <= 9) && (d0[w] <= 9);
    ee = (!ok || suppress) ? 1 : 0;
    eb = ee ? 0 : 10*d1[w] + d0[w];
    el = !ok ? 0 : (suppress ? TO+1 : 9);
    n = 0;
    while (bus.gnt == 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check({tag, " gnt"}, 32'(bus.gnt), 32'(1) << w);
    g0 = cyc;
    starts = 0;
    n = 0;
    while (bus.resp_valid == 0 && n < TO+10) begin
      if (cv_start) begin
        starts++;
        check({tag, " dig"}, 32'({cv_dig1, cv_dig0}),
              32'({4'(d1[w]), 4'(d0[w])}));
      end
      if (drop_mid && n == 4) begin
        rq[w] = 1'b0;
        bus.req = rq;
      end
      @(negedge clk);
      n++;
    end
    check({tag, " rv"}, 32'(bus.resp_valid), 32'(1) << w);
    check({tag, " bin"}, 32'(bus.resp_bin), eb);
    check({tag, " err"}, 32'(bus.resp_err), ee);
    check({tag, " lat"}, cyc - g0, el);
    check({tag, " starts"}, starts, ok ? 1 : 0);
    mptr = (w + 1) % N;
    @(negedge clk);
    check({tag, " idle"}, 32'({bus.gnt, busy}), 0);
  endtask

  task automatic all_zero(input string tag);
    check(tag, 32'({bus.gnt, bus.resp_valid, bus.resp_bin,
                    bus.resp_err, busy, cv_start, cv_dig1, cv_dig0}), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
  endtask

  initial begin
    int w, g, prev, n, cnt_rv;
    rq = '0;
    for (int i = 0; i < N; i++) begin
      d1[i] = 0;
      d0[i] = 0;
    end
    drive();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    mptr = 0;

    rq = 4'b0001; d1[0] = 4; d0[0] = 2; drive();
    txn("single", 1'b0, w, g);
    rq = '0; drive();

    do_reset();
    rq = 4'b1111;
    for (int i = 0; i < N; i++) begin
      d1[i] = $urandom_range(0, 9);
      d0[i] = $urandom_range(0, 9);
    end
    drive();
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      txn("fair", 1'b0, w, g);
      if (k > 0) check("fair period", g - prev, 11);
      prev = g;
      d1[w] = $urandom_range(0, 9);
      d0[w] = $urandom_range(0, 9);
      drive();
    end
    rq = '0; drive();

    rq = 4'b0100; d1[2] = 10; d0[2] = 3; drive();
    txn("invalid", 1'b0, w, g);
    rq = '0; drive();

    suppress = 1'b1;
    rq = 4'b1000; d1[3] = 5; d0[3] = 7; drive();
    txn("timeout", 1'b0, w, g);
    suppress = 1'b0;
    rq = '0; drive();

    rq = 4'b0001; d1[0] = 9; d0[0] = 9; drive();
    txn("max99", 1'b0, w, g);
    d1[0] = 0; d0[0] = 0; drive();
    txn("zero", 1'b0, w, g);
    rq = 4'b0010; d1[1] = 6; d0[1] = 1; drive();
    txn("drop", 1'b1, w, g);
    rq = '0; drive();

    rq = 4'b0001; d1[0] = 3; d0[0] = 3; drive();
    n = 0;
    while (bus.gnt == 0 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("rst gnt", 32'(bus.gnt), 1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rq = '0; drive();
    all_zero("rst mid");
    cnt_rv = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.resp_valid != 0 || busy) cnt_rv++;
    end
    check("rst quiet", cnt_rv, 0);
    mptr = 0;
    rq = 4'b1111; drive();
    txn("post rst", 1'b0, w, g);
    rq = '0; drive();

    rq = 4'(($urandom_range(1, 15)));
    for (int i = 0; i < N; i++) begin
      d1[i] = $urandom_range(0, 11);
      d0[i] = $urandom_range(0, 11);
    end
    drive();
    for (int k = 0; k < 30; k++) begin
      txn("rand", ($urandom_range(0, 3) == 0), w, g);
      rq[w] = 1'($urandom_range(0, 1));
      d1[w] = $urandom_range(0, 11);
      d0[w] = $urandom_range(0, 11);
      if ($urandom_range(0, 2) == 0)
        rq[$urandom_range(0, N-1)] = 1'b1;
      if (rq == 0)
        rq[$urandom_range(0, N-1)] = 1'b1;
      drive();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
